// File: rtl/cpu_pkg.sv
// Shared CPU front-end types.
// Fetch queue entry layout, fetch FSM states and the decoder NOP.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_RUN,
    FETCH_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction FIFO between imem responses and decode.
// Flush wins over push/pop; head is readable combinationally.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign head  = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  // Pointer and occupancy update; flush empties the queue outright.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; the credit scheme upstream must never overfill it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !flush))
        else $error("fetch_queue: push on full");
    end
    if (push && !flush) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request credits, redirect drain.
// Responses return in order; rsp_pc tracks the address of the next good one.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;

  logic          q_push, q_pop, q_flush;
  logic          q_empty, q_full;
  logic [CW-1:0] q_count;
  logic [CW:0]   credit;
  logic          req_fire;
  fetch_entry_t  q_head, q_wdata;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (q_wdata),
    .pop       (q_pop),
    .flush     (q_flush),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  // Next-state: issue credit, response accept/discard, redirect, FSM.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    state_d    = state_q;
    q_push     = 1'b0;
    q_flush    = 1'b0;
    q_wdata    = '{instr: imem_rsp_data, pc: rsp_pc_q + 32'd4};

    credit = {1'b0, inflight_q} + {1'b0, q_count};
    imem_req_valid = (credit < (CW+1)'(DEPTH)) && !redirect_valid;
    imem_req_addr  = fetch_pc_q;
    req_fire = imem_req_valid && imem_req_ready;

    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    q_pop = !q_empty && !stall && !redirect_valid;

    if (redirect_valid) begin
      q_flush    = 1'b1;
      fetch_pc_d = redirect_pc & ~32'h3;
      rsp_pc_d   = redirect_pc & ~32'h3;
      drop_d     = inflight_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          q_push   = 1'b1;
          rsp_pc_d = rsp_pc_q + 32'd4;
        end
      end
    end

    case (state_q)
      FETCH_RUN: begin
        if (redirect_valid && drop_d != '0) state_d = FETCH_DRAIN;
      end
      FETCH_DRAIN: begin
        if (drop_d == '0) state_d = FETCH_RUN;
      end
      default: state_d = FETCH_RUN;
    endcase
  end

  // Decode-facing outputs: NOP and zero pc when nothing is queued.
  always_comb begin
    instr_valid = !q_empty;
    instr       = instr_valid ? q_head.instr : NOP_INSTR;
    pc_out      = instr_valid ? q_head.pc : 32'h0;
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_RUN;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus scoreboard.
// Expected words are queued at request accept; monitor pops on consume.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        instr_valid;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr          (instr),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t        pend[$];
  fetch_entry_t expq[$];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           lat = 1;
  int           last_due = -1;
  logic [31:0]  model_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic sample_phase(input bit rdr);
    int d;
    @(negedge clk); #1;
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, model_pc);
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{addr: model_pc, due: d});
      expq.push_back('{instr: word_of(model_pc), pc: model_pc + 32'd4});
      model_pc = model_pc + 32'd4;
    end
    if (rdr) chk("no_req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
  endtask

  task automatic step(input bit rdy, input bit stl, input bit rdr,
                      input logic [31:0] rpc);
    @(posedge clk); #1;
    cyc++;
    imem_req_ready = rdy;
    stall          = stl;
    redirect_valid = rdr;
    redirect_pc    = rpc;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    if (rdr) begin
      expq.delete();
      model_pc = rpc & ~32'h3;
    end
    sample_phase(rdr);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (pend.size() == 0 && expq.size() == 0 && !instr_valid) begin
        done = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 1'b0, 32'h0);
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL drain_timeout: pend=%0d exp=%0d", pend.size(),
               expq.size());
    end
  endtask

  // Consumption monitor: compare head against scoreboard on every pop.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (!rst) begin
      if (instr_valid) begin
        if (!stall && !redirect_valid) begin
          if (expq.size() == 0) begin
            chk("sb_underflow_pc", pc_out, 32'hFFFF_FFFF);
          end else begin
            e = expq.pop_front();
            chk("instr", instr, e.instr);
            chk("pc_out", pc_out, e.pc);
          end
        end
      end else begin
        chk("nop_instr", instr, NOP_INSTR);
        chk("nop_pc", pc_out, 32'h0);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    model_pc       = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    imem_req_ready = 1'b1;

    // first post-reset cycle
    @(negedge clk); #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, NOP_INSTR);
    chk("rst_pc_out", pc_out, 32'h0);
    if (imem_req_valid) begin
      pend.push_back('{addr: model_pc, due: cyc + lat});
      last_due = cyc + lat;
      expq.push_back('{instr: word_of(model_pc), pc: model_pc + 32'd4});
      model_pc = model_pc + 32'd4;
    end

    // streaming with 1-cycle memory
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("first_valid", {31'b0, instr_valid}, 32'd1);
    chk("first_pc_out", pc_out, 32'h4);
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
    drain();

    // stall backpressure: credits cap at DEPTH
    lat = 1;
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    chk("stall_queued", {28'b0, 4'(expq.size())}, 32'd4);
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
    drain();

    // redirect with 3 requests in flight
    lat = 5;
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h100);
    lat = 1;
    repeat (12) step(1'b1, 1'b0, 1'b0, 32'h0);
    drain();

    // redirect coinciding with a response and stall
    lat = 1;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h203);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rr_empty", {31'b0, instr_valid}, 32'd0);
    chk("rr_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rr_req_addr", imem_req_addr, 32'h200);
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);
    drain();

    // PC wrap at top of address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
    drain();

    // random latency, ready, stall and redirects
    for (int i = 0; i < 400; i++) begin
      lat = int'($urandom_range(1, 5));
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           $urandom_range(0, 99) < 3, $urandom);
    end
    drain();

    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d expected 0", expq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
